sim_input_mapper: RTL and testbench

Parametrised player-input conditioning block for the Verilator simulation tops. Takes the packed raw `inputs` vector from the C++ harness, registers it, and produces per-player joystick, button, start, coin and pause signals in the polarity the core expects. Replaces the hand-written per-core input assigns. Adds SOCD cleaning, frame-counted coin pulse stretching, a pause toggle, and optional autofire.

---
 rtl/sim_input_pkg.sv | 32 +++
 rtl/sim_input_mapper_if.sv | 31 +++
 rtl/sim_coin_stretcher.sv | 78 +++++++
 rtl/sim_input_mapper.sv | 132 +++++++++++++
 tb/tb_sim_input_mapper.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_input_pkg.sv
// Shared types and field layout for the simulation input mapper.
// Contents: coin FSM state enum, per-player field offsets inside the raw
// harness vector, and helpers deriving the player field width and the
// start/coin offsets from the button count.
package sim_input_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_REL = 2'd2
  } coin_state_e;

  localparam int unsigned UP    = 0;
  localparam int unsigned DOWN  = 1;
  localparam int unsigned LEFT  = 2;
  localparam int unsigned RIGHT = 3;
  localparam int unsigned FIRE0 = 4;

  // Bits per player in the raw vector: 4 directions + buttons + start + coin
  function automatic int unsigned p_w(input int unsigned buttons);
    return buttons + 6;
  endfunction

  function automatic int unsigned start_off(input int unsigned buttons);
    return buttons + 4;
  endfunction

  function automatic int unsigned coin_off(input int unsigned buttons);
    return buttons + 5;
  endfunction

endpackage

// File: rtl/sim_input_mapper_if.sv
// Harness-side bus of the input mapper.
// master: drives inputs/v_blank/turbo_mask, receives conditioned controls.
// slave : the mapper itself.
interface sim_input_mapper_if #(
  parameter int unsigned PLAYERS = 2,
  parameter int unsigned BUTTONS = 2
);
  import sim_input_pkg::*;

  localparam int unsigned IN_W = PLAYERS * p_w(BUTTONS) + 1;

  logic [IN_W-1:0]            inputs;
  logic                       v_blank;
  logic [PLAYERS*BUTTONS-1:0] turbo_mask;
  logic [PLAYERS*4-1:0]       joystick;
  logic [PLAYERS*BUTTONS-1:0] buttons;
  logic [PLAYERS-1:0]         start;
  logic [PLAYERS-1:0]         coin;
  logic                       pause;

  modport master (
    output inputs, v_blank, turbo_mask,
    input  joystick, buttons, start, coin, pause
  );

  modport slave (
    input  inputs, v_blank, turbo_mask,
    output joystick, buttons, start, coin, pause
  );

endinterface

// File: rtl/sim_coin_stretcher.sv
// Per-player coin pulse stretcher: one press yields one coin pulse lasting
// COIN_MIN frame ticks, independent of how long the coin is held.
// Ports: clk_sys, reset (sync, active-high), frame_tick (1-cycle pulse),
//        coin_raw (stage-1 coin bit, active-high), coin_out (registered,
//        active-high).
module sim_coin_stretcher
  import sim_input_pkg::*;
#(
  parameter int unsigned COIN_MIN = 3
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic frame_tick,
  input  logic coin_raw,
  output logic coin_out
);

  localparam int unsigned CW = $clog2(COIN_MIN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(COIN_MIN - 1);

  coin_state_e   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_coin_prev;
  logic          r_coin_out;
  logic          w_rise;

  // Edge reference clears on reset so a coin held through reset is a new press
  assign w_rise = coin_raw & ~r_coin_prev;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_coin_prev <= 1'b0;
      r_coin_out  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_coin_prev <= coin_raw;
      r_coin_out  <= (w_state_nxt == HOLD);
    end
  end

  // Next state; frame ticks only count once already in HOLD
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = WAIT_REL;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      WAIT_REL: begin
        if (!coin_raw) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign coin_out = r_coin_out;

endmodule

// File: rtl/sim_input_mapper.sv
// Player-input conditioning for simulation tops: registers the raw harness
// vector, applies SOCD cleaning, coin stretching, pause toggle and output
// polarity. Optional autofire is enabled by defining SIM_INPUT_TURBO_EN.
// Ports: clk_sys, reset (sync, active-high), io_bus (sim_input_mapper_if
//        slave: inputs, v_blank, turbo_mask in; joystick, buttons, start,
//        coin, pause out).
module sim_input_mapper
  import sim_input_pkg::*;
#(
  parameter int unsigned PLAYERS      = 2,
  parameter int unsigned BUTTONS      = 2,
  parameter int unsigned COIN_MIN     = 3,
  parameter int unsigned TURBO_PERIOD = 4,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  sim_input_mapper_if.slave io_bus
);

  localparam int unsigned P_W     = p_w(BUTTONS);
  localparam int unsigned IN_W    = PLAYERS * P_W + 1;
  localparam int unsigned START_B = start_off(BUTTONS);
  localparam int unsigned COIN_B  = coin_off(BUTTONS);
  localparam int unsigned NB      = PLAYERS * BUTTONS;
  localparam logic        INV     = (ACTIVE_LOW != 0);

  logic [IN_W-1:0]      r_in;
  logic                 r_vb, r_vb_prev;
  logic                 r_pause_prev, r_pause;
  logic                 w_frame_tick;
  logic [NB-1:0]        w_turbo_gate;
  logic [PLAYERS*4-1:0] w_joy, r_joy;
  logic [NB-1:0]        w_btn, r_btn;
  logic [PLAYERS-1:0]   w_start, r_start;
  logic [PLAYERS-1:0]   w_coin;

  // Stage 1 capture plus frame and pause edge references
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_in         <= '0;
      r_vb         <= 1'b0;
      r_vb_prev    <= 1'b0;
      r_pause_prev <= 1'b0;
      r_pause      <= 1'b0;
    end else begin
      r_in         <= io_bus.inputs;
      r_vb         <= io_bus.v_blank;
      r_vb_prev    <= r_vb;
      r_pause_prev <= r_in[IN_W-1];
      if (r_in[IN_W-1] & ~r_pause_prev) r_pause <= ~r_pause;
    end
  end

  assign w_frame_tick = r_vb & ~r_vb_prev;

`ifdef SIM_INPUT_TURBO_EN
  localparam int unsigned TW = $clog2(TURBO_PERIOD + 1);
  logic [TW-1:0] r_turbo_cnt;
  logic          r_turbo_phase;

  // Shared autofire phase, toggled every TURBO_PERIOD frame ticks
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_turbo_cnt   <= '0;
      r_turbo_phase <= 1'b0;
    end else if (w_frame_tick) begin
      if (r_turbo_cnt == TW'(TURBO_PERIOD - 1)) begin
        r_turbo_cnt   <= '0;
        r_turbo_phase <= ~r_turbo_phase;
      end else begin
        r_turbo_cnt <= r_turbo_cnt + TW'(1);
      end
    end
  end

  assign w_turbo_gate = ~io_bus.turbo_mask | {NB{r_turbo_phase}};
`else
  logic w_unused_turbo;
  assign w_unused_turbo = ^{io_bus.turbo_mask, 32'(TURBO_PERIOD)};
  assign w_turbo_gate   = '1;
`endif

  // SOCD cleaning: opposing directions pressed together cancel out
  always_comb begin
    w_joy   = '0;
    w_btn   = '0;
    w_start = '0;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      w_joy[p*4+0] = r_in[p*P_W+UP]    & ~r_in[p*P_W+DOWN];
      w_joy[p*4+1] = r_in[p*P_W+DOWN]  & ~r_in[p*P_W+UP];
      w_joy[p*4+2] = r_in[p*P_W+LEFT]  & ~r_in[p*P_W+RIGHT];
      w_joy[p*4+3] = r_in[p*P_W+RIGHT] & ~r_in[p*P_W+LEFT];
      w_btn[p*BUTTONS +: BUTTONS] = r_in[p*P_W+FIRE0 +: BUTTONS]
                                  & w_turbo_gate[p*BUTTONS +: BUTTONS];
      w_start[p] = r_in[p*P_W+START_B];
    end
  end

  // Output register with core polarity applied
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_joy   <= {(PLAYERS*4){INV}};
      r_btn   <= {NB{INV}};
      r_start <= {PLAYERS{INV}};
    end else begin
      r_joy   <= w_joy ^ {(PLAYERS*4){INV}};
      r_btn   <= w_btn ^ {NB{INV}};
      r_start <= w_start ^ {PLAYERS{INV}};
    end
  end

  for (genvar p = 0; p < int'(PLAYERS); p++) begin : g_coin
    sim_coin_stretcher #(
      .COIN_MIN (COIN_MIN)
    ) u_coin (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .frame_tick (w_frame_tick),
      .coin_raw   (r_in[p*P_W+COIN_B]),
      .coin_out   (w_coin[p])
    );
  end

  assign io_bus.joystick = r_joy;
  assign io_bus.buttons  = r_btn;
  assign io_bus.start    = r_start;
  // Stretcher output is already registered; only the polarity is applied here
  assign io_bus.coin     = w_coin ^ {PLAYERS{INV}};
  assign io_bus.pause    = r_pause;

endmodule

// File: tb/tb_sim_input_mapper.sv
// Scoreboard bench for sim_input_mapper (PLAYERS=2, BUTTONS=2, COIN_MIN=3,
// TURBO_PERIOD=2, ACTIVE_LOW=1). Stimulus pushes expected output snapshots
// tagged with the cycle they must appear; a negedge monitor compares them.
module tb_sim_input_mapper;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  sim_input_mapper_if #(.PLAYERS(2), .BUTTONS(2)) bus_if ();

  sim_input_mapper #(
    .PLAYERS      (2),
    .BUTTONS      (2),
    .COIN_MIN     (3),
    .TURBO_PERIOD (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .io_bus  (bus_if)
  );

  // Snapshot layout: {joystick[7:0], buttons[3:0], start[1:0], coin[1:0], pause}
  localparam logic [16:0] M_JOY  = 17'h1FE00;
  localparam logic [16:0] M_BTN  = 17'h001E0;
  localparam logic [16:0] M_COIN = 17'h00006;
  localparam logic [16:0] M_PZ   = 17'h00001;
  localparam logic [16:0] M_ALL  = 17'h1FFFF;

  typedef struct {
    int          cyc;
    string       nm;
    logic [16:0] e;
    logic [16:0] m;
  } exp_t;

  exp_t sb_q[$];

  function automatic logic [16:0] mk(input logic [7:0] j, input logic [3:0] b,
                                     input logic [1:0] s, input logic [1:0] c,
                                     input logic p);
    return {j, b, s, c, p};
  endfunction

  task automatic push(input int c, input string nm, input logic [16:0] e,
                      input logic [16:0] m);
    exp_t x;
    x.cyc = c; x.nm = nm; x.e = e; x.m = m;
    sb_q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Monitor: compare every expectation whose cycle has come
  always @(negedge clk_sys) begin
    logic [16:0] snap;
    snap = {bus_if.joystick, bus_if.buttons, bus_if.start, bus_if.coin, bus_if.pause};
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        n_checks++;
        if ((snap & sb_q[i].m) !== (sb_q[i].e & sb_q[i].m)) begin
          n_fail++;
          $display("FAIL %s cyc=%0d got=%h want=%h mask=%h",
                   sb_q[i].nm, cyc, snap & sb_q[i].m, sb_q[i].e & sb_q[i].m, sb_q[i].m);
        end
        sb_q.delete(i);
      end
    end
  end

  logic [16:0] idle;
  logic [3:0]  e_btn;
  logic        ph;
  int          c, r, f;

  initial begin
    idle = mk(8'hFF, 4'hF, 2'b11, 2'b11, 1'b0);
    bus_if.inputs     = '0;
    bus_if.v_blank    = 1'b0;
    bus_if.turbo_mask = '0;

    // Reset values
    step(1);
    push(cyc + 1, "rst_hold", idle, M_ALL);
    step(2);
    reset = 1'b0;
    push(cyc + 1, "rst_idle", idle, M_ALL);
    step(3);

    // Direct idle checks after reset release
    n_checks++;
    if (bus_if.joystick !== 8'hFF) begin
      n_fail++;
      $display("FAIL idle_joy got=%h", bus_if.joystick);
    end
    n_checks++;
    if (bus_if.buttons !== 4'hF) begin
      n_fail++;
      $display("FAIL idle_btn got=%h", bus_if.buttons);
    end
    n_checks++;
    if (bus_if.start !== 2'b11) begin
      n_fail++;
      $display("FAIL idle_start got=%b", bus_if.start);
    end
    n_checks++;
    if (bus_if.coin !== 2'b11) begin
      n_fail++;
      $display("FAIL idle_coin got=%b", bus_if.coin);
    end
    n_checks++;
    if (bus_if.pause !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_pause got=%b", bus_if.pause);
    end

    // SOCD: left+right+up on player 0, then up+down+right with player 1 left
    c = cyc;
    bus_if.inputs = 17'h0000D;
    push(c + 1, "socd_lat", idle, M_JOY);
    push(c + 2, "socd_lr", mk(8'hFE, 4'h0, 2'b0, 2'b0, 1'b0), M_JOY);
    step(3);
    bus_if.inputs = 17'h0040B;
    push(cyc + 2, "socd_ud_p1", mk(8'hB7, 4'h0, 2'b0, 2'b0, 1'b0), M_JOY);
    step(3);
    bus_if.inputs = '0;
    step(3);

    // Buttons/start pass-through: p0 fire0, p1 fire1, p1 start
    bus_if.inputs = 17'h06010;
    push(cyc + 2, "btn_start", mk(8'hFF, 4'b0110, 2'b01, 2'b11, 1'b0), M_ALL);
    step(3);
    bus_if.inputs = '0;
    step(3);

    // Player 1 coin pressed for one cycle, ten frames follow
    c = cyc;
    bus_if.inputs[15] = 1'b1;
    push(c + 1, "coin_lat", mk(8'h0, 4'h0, 2'b0, 2'b11, 1'b0), M_COIN);
    push(c + 2, "coin_on",  mk(8'h0, 4'h0, 2'b0, 2'b01, 1'b0), M_COIN);
    step(1);
    bus_if.inputs[15] = 1'b0;
    step(3);
    for (int k = 0; k < 10; k++) begin
      f = cyc;
      bus_if.v_blank = 1'b1;
      if (k == 1) push(f + 2, "coin_tick2", mk(8'h0, 4'h0, 2'b0, 2'b01, 1'b0), M_COIN);
      if (k == 2) begin
        push(f + 1, "coin_tick3_pre", mk(8'h0, 4'h0, 2'b0, 2'b01, 1'b0), M_COIN);
        push(f + 2, "coin_off", mk(8'h0, 4'h0, 2'b0, 2'b11, 1'b0), M_COIN);
      end
      step(2);
      bus_if.v_blank = 1'b0;
      step(4);
    end
    push(cyc + 1, "coin_idle", mk(8'h0, 4'h0, 2'b0, 2'b11, 1'b0), M_COIN);
    step(2);

    // Player 1 coin held for twenty frames: still one pulse
    c = cyc;
    bus_if.inputs[15] = 1'b1;
    push(c + 2, "hold_on", mk(8'h0, 4'h0, 2'b0, 2'b01, 1'b0), M_COIN);
    step(4);
    for (int k = 0; k < 20; k++) begin
      f = cyc;
      bus_if.v_blank = 1'b1;
      if (k == 2) begin
        push(f + 1, "hold_tick3_pre", mk(8'h0, 4'h0, 2'b0, 2'b01, 1'b0), M_COIN);
        push(f + 2, "hold_off", mk(8'h0, 4'h0, 2'b0, 2'b11, 1'b0), M_COIN);
      end
      if (k == 10 || k == 19)
        push(f + 3, "hold_once", mk(8'h0, 4'h0, 2'b0, 2'b11, 1'b0), M_COIN);
      step(2);
      bus_if.v_blank = 1'b0;
      step(4);
    end
    bus_if.inputs[15] = 1'b0;
    step(4);

    // Pause toggles on each rising edge
    for (int j = 0; j < 3; j++) begin
      bus_if.inputs[16] = 1'b1;
      push(cyc + 1, "pause_lat", mk(8'h0, 4'h0, 2'b0, 2'b0, (j % 2) == 1), M_PZ);
      push(cyc + 2, "pause_tog", mk(8'h0, 4'h0, 2'b0, 2'b0, (j % 2) == 0), M_PZ);
      push(cyc + 4, "pause_hold", mk(8'h0, 4'h0, 2'b0, 2'b0, (j % 2) == 0), M_PZ);
      step(5);
      bus_if.inputs[16] = 1'b0;
      step(5);
    end

    // Autofire (or turbo_mask ignored), from a fresh reset
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    bus_if.inputs = 17'h00030;
`ifdef SIM_INPUT_TURBO_EN
    bus_if.turbo_mask = 4'b0001;
    push(cyc + 2, "turbo_init", mk(8'h0, 4'b1101, 2'b0, 2'b0, 1'b0), M_BTN);
`else
    bus_if.turbo_mask = 4'b1111;
    push(cyc + 2, "mask_ignored", mk(8'h0, 4'b1100, 2'b0, 2'b0, 1'b0), M_BTN);
`endif
    step(4);
    for (int k = 0; k < 8; k++) begin
      f = cyc;
      bus_if.v_blank = 1'b1;
`ifdef SIM_INPUT_TURBO_EN
      ph    = 1'(((k + 1) / 2) % 2);
      e_btn = {2'b11, 1'b0, ~ph};
`else
      ph    = 1'b0;
      e_btn = {2'b11, 2'b00};
`endif
      push(f + 4, "turbo_frame", mk(8'h0, e_btn, 2'b0, 2'b0, ph), M_BTN);
      step(2);
      bus_if.v_blank = 1'b0;
      step(4);
    end
    bus_if.inputs     = '0;
    bus_if.turbo_mask = '0;
    step(4);

    // Reset in the middle of a coin pulse with the coin still held
    c = cyc;
    bus_if.inputs[7] = 1'b1;
    push(c + 2, "crst_on", mk(8'h0, 4'h0, 2'b0, 2'b10, 1'b0), M_COIN);
    step(3);
    reset = 1'b1;
    r = cyc;
    push(r + 1, "crst_idle", idle, M_ALL);
    push(r + 2, "crst_wait", mk(8'h0, 4'h0, 2'b0, 2'b11, 1'b0), M_COIN);
    push(r + 3, "crst_new",  mk(8'h0, 4'h0, 2'b0, 2'b10, 1'b0), M_COIN);
    step(1);
    reset = 1'b0;
    step(3);
    for (int k = 0; k < 5; k++) begin
      f = cyc;
      bus_if.v_blank = 1'b1;
      if (k == 1) push(f + 3, "crst_tick2", mk(8'h0, 4'h0, 2'b0, 2'b10, 1'b0), M_COIN);
      if (k == 2) begin
        push(f + 1, "crst_tick3_pre", mk(8'h0, 4'h0, 2'b0, 2'b10, 1'b0), M_COIN);
        push(f + 2, "crst_off", mk(8'h0, 4'h0, 2'b0, 2'b11, 1'b0), M_COIN);
      end
      step(2);
      bus_if.v_blank = 1'b0;
      step(4);
    end
    bus_if.inputs = '0;
    step(10);

    // Anything still queued was never sampled
    foreach (sb_q[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s never sampled (due cyc=%0d, now %0d)", sb_q[i].nm, sb_q[i].cyc, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
